// File: rtl/cmd_sequencer.sv
// Command sequencer: queues 16-bit commands and plays them to RemoteComm one at a time,
// checking each response. Define CMD_SEQUENCER_RETRY_EN to allow one resend per failed command.
module cmd_sequencer #(
    parameter int         DEPTH    = 8,
    parameter int         TIMEOUT  = 1000000,
    parameter logic [7:0] RESP_ACK = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_cmd,
    input  logic [15:0] wr_data,
    output logic        full,
    output logic        empty,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  cmds_done,
    output logic [15:0] cmd,
    output logic        send_cmd,
    input  logic        cmd_sent,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_rx_rdy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_SEND, S_WAIT_SENT, S_WAIT_RESP, S_CHECK, S_FIN, S_ERR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [7:0]    resp_q, resp_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    cmds_done_q, cmds_done_d;
    logic          retry_q, retry_d;
    logic          push, pop, flush, fail, wr_en;
    logic [1:0]    fail_code;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = wr_cmd && !full;
    assign wr_en = push && !flush;

    // State and datapath register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_q       <= '0;
            resp_q      <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            cmds_done_q <= '0;
            retry_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_q       <= cmd_d;
            resp_q      <= resp_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
            cmds_done_q <= cmds_done_d;
            retry_q     <= retry_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        resp_d      = resp_q;
        timer_d     = timer_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        cmds_done_d = cmds_done_q;
        retry_d     = retry_q;
        pop         = 1'b0;
        flush       = 1'b0;
        fail        = 1'b0;
        fail_code   = 2'b00;
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !empty) begin
                        state_d     = S_POP;
                        err_d       = 1'b0;
                        err_code_d  = 2'b00;
                        cmds_done_d = '0;
                    end
                end
                S_POP: begin
                    cmd_d   = mem_q[rd_ptr_q];
                    pop     = 1'b1;
                    retry_d = 1'b0;
                    state_d = S_SEND;
                end
                S_SEND: begin
                    timer_d = '0;
                    state_d = S_WAIT_SENT;
                end
                S_WAIT_SENT: begin
                    if (cmd_sent) begin
                        timer_d = '0;
                        state_d = S_WAIT_RESP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_WAIT_RESP: begin
                    if (resp_rdy) begin
                        resp_d  = resp;
                        state_d = S_CHECK;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        fail      = 1'b1;
                        fail_code = 2'b01;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (resp_q == RESP_ACK) begin
                        if (cmds_done_q != 8'hFF) cmds_done_d = cmds_done_q + 8'd1;
                        state_d = empty ? S_FIN : S_POP;
                    end else begin
                        fail      = 1'b1;
                        fail_code = 2'b10;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                S_ERR: begin
                    flush   = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (fail) begin
`ifdef CMD_SEQUENCER_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                state_d = S_SEND;
            end else begin
                state_d    = S_ERR;
                err_d      = 1'b1;
                err_code_d = fail_code;
            end
`else
            state_d    = S_ERR;
            err_d      = 1'b1;
            err_code_d = fail_code;
`endif
        end
    end

    // FIFO pointers; a flush discards any push arriving in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        send_cmd   = (state_q == S_SEND);
        clr_rx_rdy = (state_q == S_CHECK);
        done       = (state_q == S_FIN);
        busy       = (state_q != S_IDLE);
        cmd        = cmd_q;
        err        = err_q;
        err_code   = err_code_q;
        cmds_done  = cmds_done_q;
    end

endmodule

// File: doc/cmd_sequencer.md
CMD_SEQUENCER -- requirements
Module: cmd_sequencer

Interface
REQ-001 Parameters SHALL be: DEPTH, 8, command FIFO entries (power of 2); TIMEOUT, 1000000, max clk cycles waiting for cmd_sent or resp_rdy; RESP_ACK, 8'hA5, response value meaning command complete.
REQ-002 Ports, clock and reset first, SHALL be: clk in 1 system clock; rst in 1 synchronous active-high reset; one clock domain only.
REQ-003 wr_cmd in 1 push strobe; wr_data in 16 command to queue; full out 1 FIFO full; empty out 1 FIFO empty.
REQ-004 start in 1 begin executing queue; abort in 1 stop sequence; busy out 1 sequence running; done out 1 one-cycle pulse when the queue completes OK.
REQ-005 err out 1 sticky error flag; err_code out 2 with 01 timeout and 10 bad response; cmds_done out 8 count of acknowledged commands.
REQ-006 cmd out 16 command to RemoteComm; send_cmd out 1 one-cycle send strobe; cmd_sent in 1 RemoteComm transmit complete; resp_rdy in 1 response valid; resp in 8 response byte; clr_rx_rdy out 1 one-cycle response consume strobe.

Function
REQ-007 FIFO SHALL accept a push when wr_cmd=1 and full=0; a push while full SHALL be dropped and leave contents unchanged.
REQ-008 A simultaneous push and internal pop SHALL both take effect and leave the occupancy unchanged; pointers SHALL wrap modulo DEPTH.
REQ-009 The FSM SHALL use states IDLE, POP, SEND, WAIT_SENT, WAIT_RESP, CHECK, FIN, ERR.
REQ-010 IDLE: start=1 and empty=0 -> POP; start with empty=1 SHALL be ignored.
REQ-011 POP SHALL register the head entry into cmd, advance the read pointer, and go to SEND.
REQ-012 SEND SHALL assert send_cmd for exactly one cycle, clear the timeout counter, and go to WAIT_SENT.
REQ-013 WAIT_SENT: cmd_sent=1 -> WAIT_RESP with timer cleared; timer reaching TIMEOUT-1 -> ERR with err_code=01.
REQ-014 WAIT_RESP: resp_rdy=1 -> CHECK with resp captured; timer reaching TIMEOUT-1 -> ERR with err_code=01.
REQ-015 CHECK SHALL pulse clr_rx_rdy for one cycle; if resp==RESP_ACK, cmds_done SHALL increment (saturating at 255), going to POP if empty=0 else FIN; otherwise -> ERR with err_code=10.
REQ-016 FIN SHALL pulse done for one cycle and return to IDLE.
REQ-017 ERR SHALL set err, flush the FIFO (pointers equal), and go to IDLE; err and err_code SHALL hold until the next accepted start, which clears them and cmds_done.
REQ-018 abort=1 in any non-IDLE state SHALL flush the FIFO and return to IDLE next cycle without done or err; abort has priority over all other transitions.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 cmd SHALL hold its value between POP loads; send_cmd and clr_rx_rdy SHALL never be asserted in the same cycle.
REQ-021 Pushes during a running sequence SHALL be accepted and executed in the same sequence.

Reset
REQ-022 rst=1 at a clock edge SHALL force IDLE, empty FIFO, and outputs cmd=16'h0000, send_cmd=0, clr_rx_rdy=0, busy=0, done=0, err=0, err_code=00, cmds_done=0, full=0, empty=1.
REQ-023 rst mid-sequence SHALL abandon the in-flight command with no done or clr_rx_rdy pulse.

Configuration
REQ-024 Macro CMD_SEQUENCER_RETRY_EN: when defined, the first timeout or bad response on a command SHALL re-enter SEND with the same cmd once, and only a second failure SHALL go to ERR.
REQ-025 When the macro is not defined, the first failure SHALL go directly to ERR; the port list is identical in both builds.

Verification
REQ-026 Push 16'h2000, start, model acks cmd_sent after 50 cycles and resp=8'hA5 -> one send_cmd pulse with cmd=16'h2000, one clr_rx_rdy pulse, done pulse, cmds_done=1.
REQ-027 Push 3 commands, all acked -> 3 send_cmd pulses in FIFO order, cmds_done=3, single done pulse, empty=1.
REQ-028 Push 9 commands with DEPTH=8 -> full=1 after the 8th push, the 9th push is dropped, and exactly 8 commands are sent.
REQ-029 Model responds 8'h5A, retry disabled -> err=1, err_code=10, FIFO flushed, no done pulse; the next start clears err.
REQ-030 Model never asserts cmd_sent, TIMEOUT=100 -> ERR 100 cycles after send_cmd with err_code=01; with CMD_SEQUENCER_RETRY_EN there is a second send_cmd first.
REQ-031 abort asserted in WAIT_RESP, or rst asserted mid-sequence -> busy=0 next cycle, FIFO empty, no done, err=0.
